drop_scheduler: RTL and testbench



---
 rtl/drop_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_drop_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/drop_scheduler.sv
// Game sequencer for the 40x30 hex-letter display: three falling-byte slots,
// LFSR spawning, switch matching, score/lives bookkeeping and game-over control.
module drop_scheduler #(
    parameter int         TICK_DIV    = 2500000,
    parameter int         SPAWN_TICKS = 8,
    parameter int         FLOOR_ROW   = 29,
    parameter int         START_LIVES = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] switches,
    input  logic       fire,
    output logic [7:0] letter,
    output logic [4:0] ypos1,
    output logic [4:0] ypos2,
    output logic [4:0] ypos3,
    output logic [2:0] active,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SPN_W = $clog2(SPAWN_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [SPN_W-1:0] SPN_WRAP  = SPN_W'(SPAWN_TICKS);
    localparam logic [4:0]       FLOOR     = 5'(FLOOR_ROW);
    localparam logic [4:0]       ROW_NONE  = 5'd31;
    localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SPN_W-1:0] spawn_q, spawn_d;
    logic [SPN_W-1:0] spawn_inc;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [2:0]       act_q, act_d;
    logic [4:0]       row_q [3];
    logic [4:0]       row_d [3];
    logic [7:0]       byte_q [3];
    logic [7:0]       byte_d [3];
    logic [7:0]       score_q, score_d;
    logic [2:0]       lives_q, lives_d;
    logic [7:0]       letter_q, letter_d;
    logic             over_q, over_d;

    logic             tick;
    logic             hit;
    logic [4:0]       hit_row;
    logic [2:0]       hit_mask;
    logic [2:0]       free_pre;
    logic [1:0]       misses;
    logic             placed;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        spawn_d   = spawn_q;
        act_d     = act_q;
        row_d     = row_q;
        byte_d    = byte_q;
        score_d   = score_q;
        lives_d   = lives_q;
        letter_d  = 8'h00;
        over_d    = 1'b0;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tick      = (state_q == S_PLAY) && (div_q == DIV_LAST);
        spawn_inc = spawn_q + 1'b1;
        free_pre  = 3'b000;
        misses    = 2'd0;
        placed    = 1'b0;

        // Deepest matching slot wins; strict compare keeps the lowest index on ties.
        hit      = 1'b0;
        hit_row  = 5'd0;
        hit_mask = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (fire && (state_q == S_PLAY) && act_q[i] && (byte_q[i] == switches) &&
                (!hit || (row_q[i] > hit_row))) begin
                hit         = 1'b1;
                hit_row     = row_q[i];
                hit_mask    = 3'b000;
                hit_mask[i] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_PLAY;
                    act_d   = 3'b000;
                    row_d   = '{ROW_NONE, ROW_NONE, ROW_NONE};
                    score_d = 8'd0;
                    lives_d = LIVES_INIT;
                    div_d   = '0;
                    spawn_d = '0;
                end
            end
            S_PLAY: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (hit) begin
                    act_d = act_q & ~hit_mask;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    for (int i = 0; i < 3; i++) begin
                        if (hit_mask[i]) begin
                            row_d[i] = ROW_NONE;
                        end
                    end
                end
                if (tick) begin
                    // Slots freed by a miss this tick must not be refilled this tick.
                    free_pre = ~act_d;
                    for (int i = 0; i < 3; i++) begin
                        if (act_d[i]) begin
                            if (row_q[i] == FLOOR) begin
                                act_d[i] = 1'b0;
                                row_d[i] = ROW_NONE;
                                misses   = misses + 2'd1;
                            end else begin
                                row_d[i] = row_q[i] + 5'd1;
                            end
                        end
                    end
                    if (spawn_inc == SPN_WRAP) begin
                        spawn_d = '0;
                        for (int i = 0; i < 3; i++) begin
                            if (free_pre[i] && !placed) begin
                                placed    = 1'b1;
                                act_d[i]  = 1'b1;
                                row_d[i]  = 5'd0;
                                byte_d[i] = lfsr_q;
                            end
                        end
                    end else begin
                        spawn_d = spawn_inc;
                    end
                    lives_d = ({1'b0, misses} >= lives_q) ? 3'd0 : lives_q - {1'b0, misses};
                    if (lives_d == 3'd0) begin
                        state_d = S_OVER;
                        act_d   = 3'b000;
                        row_d   = '{ROW_NONE, ROW_NONE, ROW_NONE};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 2; i >= 0; i--) begin
            if (act_d[i]) begin
                letter_d = byte_d[i];
            end
        end
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            spawn_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            act_q    <= 3'b000;
            row_q    <= '{ROW_NONE, ROW_NONE, ROW_NONE};
            score_q  <= 8'd0;
            lives_q  <= 3'd0;
            letter_q <= 8'h00;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            spawn_q  <= spawn_d;
            lfsr_q   <= lfsr_d;
            act_q    <= act_d;
            row_q    <= row_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            letter_q <= letter_d;
            over_q   <= over_d;
        end
    end

    // Slot bytes are only observed while the slot is active, so they need no reset.
    always_ff @(posedge clock) begin
        byte_q <= byte_d;
    end

    assign letter    = letter_q;
    assign ypos1     = row_q[0];
    assign ypos2     = row_q[1];
    assign ypos3     = row_q[2];
    assign active    = act_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler: a small-tick instance for gameplay and a
// second instance whose spawn period equals the LFSR period for equal-byte matching.
module tb_drop_scheduler;

    logic       clk = 1'b0;
    logic       reset, start, fire, start2, fire2;
    logic [7:0] switches, sw2;
    logic [7:0] letter, ltr2, score, sc2;
    logic [4:0] ypos1, ypos2, ypos3, y21, y22, y23;
    logic [2:0] active, act2, lives, lv2;
    logic       game_over, go2;

    int n_chk = 0;
    int n_fail = 0;
    int t = 0;
    logic [7:0] m_lfsr;
    logic [7:0] b [5];
    logic [7:0] nm, x;

    always #5 clk = ~clk;

    drop_scheduler #(.TICK_DIV(4), .SPAWN_TICKS(2), .FLOOR_ROW(29), .START_LIVES(3),
                     .LFSR_SEED(8'hA5)) u_dut (
        .clock(clk), .reset(reset), .start(start), .switches(switches), .fire(fire),
        .letter(letter), .ypos1(ypos1), .ypos2(ypos2), .ypos3(ypos3), .active(active),
        .score(score), .lives(lives), .game_over(game_over));

    drop_scheduler #(.TICK_DIV(51), .SPAWN_TICKS(5), .FLOOR_ROW(29), .START_LIVES(3),
                     .LFSR_SEED(8'hA5)) u_dut2 (
        .clock(clk), .reset(reset), .start(start2), .switches(sw2), .fire(fire2),
        .letter(ltr2), .ypos1(y21), .ypos2(y22), .ypos3(y23), .active(act2),
        .score(sc2), .lives(lv2), .game_over(go2));

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) m_lfsr <= reset ? 8'hA5 : lfsr_next(m_lfsr);

    typedef struct {
        logic       st;
        logic       fi;
        logic [7:0] sw;
        int         n;
        logic       cap;
        logic [2:0] act;
        logic [4:0] y1, y2, y3;
        logic [7:0] sc;
        logic [2:0] lv;
        logic       go;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm_s, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", nm_s, got, exp, t);
        end
    endtask

    task automatic chk1(input string p, input logic [2:0] a, input logic [4:0] e1,
                        input logic [4:0] e2, input logic [4:0] e3, input logic [7:0] sc,
                        input logic [2:0] lv, input logic go);
        chk({p, ".active"}, 32'(active), 32'(a));
        chk({p, ".ypos1"}, 32'(ypos1), 32'(e1));
        chk({p, ".ypos2"}, 32'(ypos2), 32'(e2));
        chk({p, ".ypos3"}, 32'(ypos3), 32'(e3));
        chk({p, ".score"}, 32'(score), 32'(sc));
        chk({p, ".lives"}, 32'(lives), 32'(lv));
        chk({p, ".game_over"}, 32'(game_over), 32'(go));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        t = t + 1;
    endtask

    task automatic run_to(input int k);
        while (t < k) cyc();
    endtask

    initial begin
        int cap_n;
        reset = 1'b1; start = 1'b0; fire = 1'b0; switches = 8'h00;
        start2 = 1'b0; fire2 = 1'b0; sw2 = 8'h00;
        cap_n = 0;

        tbl[0] = '{1'b0, 1'b0, 8'h00, 20, 1'b0, 3'b000, 5'd31, 5'd31, 5'd31, 8'd0, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'hA5, 1,  1'b0, 3'b000, 5'd31, 5'd31, 5'd31, 8'd0, 3'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1,  1'b0, 3'b000, 5'd31, 5'd31, 5'd31, 8'd0, 3'd3, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 7,  1'b0, 3'b000, 5'd31, 5'd31, 5'd31, 8'd0, 3'd3, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1,  1'b1, 3'b001, 5'd0,  5'd31, 5'd31, 8'd0, 3'd3, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 3,  1'b0, 3'b001, 5'd0,  5'd31, 5'd31, 8'd0, 3'd3, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1,  1'b0, 3'b001, 5'd1,  5'd31, 5'd31, 8'd0, 3'd3, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 3,  1'b0, 3'b001, 5'd1,  5'd31, 5'd31, 8'd0, 3'd3, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1,  1'b1, 3'b011, 5'd2,  5'd0,  5'd31, 8'd0, 3'd3, 1'b0};

        cyc(); cyc();
        reset = 1'b0;
        chk("reset.letter", 32'(letter), 32'h0);

        for (int i = 0; i < 9; i++) begin
            start = tbl[i].st; fire = tbl[i].fi; switches = tbl[i].sw;
            if (tbl[i].cap) begin
                b[cap_n] = m_lfsr;
                cap_n++;
            end
            cyc();
            if (tbl[i].st) t = 0;
            start = 1'b0; fire = 1'b0;
            repeat (tbl[i].n - 1) cyc();
            chk1($sformatf("vec%0d", i), tbl[i].act, tbl[i].y1, tbl[i].y2, tbl[i].y3,
                 tbl[i].sc, tbl[i].lv, tbl[i].go);
            if (tbl[i].cap) chk($sformatf("vec%0d.letter", i), 32'(letter), 32'(b[0]));
        end

        // Non-matching fire, then matching fire on slot 0.
        nm = b[0] + 8'd1;
        if (nm == b[1]) nm = b[0] + 8'd2;
        switches = nm; fire = 1'b1; cyc(); fire = 1'b0;
        chk1("nomatch", 3'b011, 5'd2, 5'd0, 5'd31, 8'd0, 3'd3, 1'b0);
        switches = b[0]; fire = 1'b1; cyc(); fire = 1'b0;
        chk1("match0", 3'b010, 5'd31, 5'd0, 5'd31, 8'd1, 3'd3, 1'b0);
        chk("match0.letter", 32'(letter), 32'(b[1]));

        run_to(23); b[2] = m_lfsr; cyc();
        chk1("spawn24", 3'b011, 5'd0, 5'd2, 5'd31, 8'd1, 3'd3, 1'b0);
        chk("spawn24.letter", 32'(letter), 32'(b[2]));
        run_to(31); b[3] = m_lfsr; cyc();
        chk1("spawn32", 3'b111, 5'd2, 5'd4, 5'd0, 8'd1, 3'd3, 1'b0);

        run_to(129); switches = b[2]; fire = 1'b1; cyc(); fire = 1'b0;
        chk1("match130", 3'b110, 5'd31, 5'd28, 5'd24, 8'd2, 3'd3, 1'b0);

        // Match on the floor row during a tick: scored, not a miss.
        run_to(135);
        chk("floor.pre", 32'(ypos2), 32'd29);
        b[4] = m_lfsr; switches = b[1]; fire = 1'b1; cyc(); fire = 1'b0;
        chk1("floormatch", 3'b101, 5'd0, 5'd31, 5'd26, 8'd3, 3'd3, 1'b0);
        chk("floormatch.letter", 32'(letter), 32'(b[4]));

        run_to(151);
        chk("miss1.pre.lives", 32'(lives), 32'd3);
        cyc();
        chk1("miss1", 3'b011, 5'd4, 5'd2, 5'd31, 8'd3, 3'd2, 1'b0);
        run_to(255);
        chk("miss2.pre.lives", 32'(lives), 32'd2);
        cyc();
        chk1("miss2", 3'b110, 5'd31, 5'd28, 5'd24, 8'd3, 3'd1, 1'b0);
        run_to(263);
        chk("miss3.pre.go", 32'(game_over), 32'd0);
        cyc();
        chk1("miss3", 3'b000, 5'd31, 5'd31, 5'd31, 8'd3, 3'd0, 1'b1);

        switches = 8'h00; fire = 1'b1; cyc(); fire = 1'b0;
        repeat (4) cyc();
        chk1("over.idle", 3'b000, 5'd31, 5'd31, 5'd31, 8'd3, 3'd0, 1'b1);

        start = 1'b1; cyc(); start = 1'b0; t = 0;
        chk1("restart", 3'b000, 5'd31, 5'd31, 5'd31, 8'd0, 3'd3, 1'b0);
        run_to(14);
        chk("restart.active", 32'(active), 32'b001);

        // Reset wins over simultaneous start and fire.
        reset = 1'b1; start = 1'b1; fire = 1'b1; switches = b[0];
        cyc();
        reset = 1'b0; start = 1'b0; fire = 1'b0;
        chk1("midreset", 3'b000, 5'd31, 5'd31, 5'd31, 8'd0, 3'd0, 1'b0);
        chk("midreset.letter", 32'(letter), 32'h0);

        // Spawn period of 255 cycles repeats the LFSR byte in all three slots.
        start2 = 1'b1; cyc(); start2 = 1'b0; t = 0;
        chk("d2.start.lives", 32'(lv2), 32'd3);
        run_to(254); x = m_lfsr; cyc();
        chk("d2.s0.active", 32'(act2), 32'b001);
        chk("d2.s0.letter", 32'(ltr2), 32'(x));
        run_to(510);
        chk("d2.s1.active", 32'(act2), 32'b011);
        chk("d2.s1.ypos1", 32'(y21), 32'd5);
        run_to(765);
        chk("d2.s2.active", 32'(act2), 32'b111);
        chk("d2.s2.rows", {17'd0, y21, y22, y23}, {17'd0, 5'd10, 5'd5, 5'd0});
        chk("d2.s2.letter", 32'(ltr2), 32'(x));
        sw2 = x; fire2 = 1'b1; cyc(); fire2 = 1'b0;
        chk("d2.m1.active", 32'(act2), 32'b110);
        chk("d2.m1.rows", {17'd0, y21, y22, y23}, {17'd0, 5'd31, 5'd5, 5'd0});
        chk("d2.m1.score", 32'(sc2), 32'd1);
        fire2 = 1'b1; cyc(); fire2 = 1'b0;
        chk("d2.m2.active", 32'(act2), 32'b100);
        chk("d2.m2.rows", {17'd0, y21, y22, y23}, {17'd0, 5'd31, 5'd31, 5'd0});
        chk("d2.m2.score", 32'(sc2), 32'd2);
        chk("d2.m2.lives", 32'(lv2), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
